// File: rtl/car_pkg.sv
// Shared types for the car control path: FSM state encodings, turn decisions
// and the move-selection rules used by the auto-drive sequencer.
package car_pkg;

  localparam int CLK_HZ = 500;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CRUISE    = 3'd1,
    TRIGGER   = 3'd2,
    WAIT_ACK  = 3'd3,
    WAIT_DONE = 3'd4,
    SETTLE    = 3'd5,
    FAULT     = 3'd6
  } state_t;

  typedef enum logic [1:0] {
    LEFT     = 2'd0,
    RIGHT    = 2'd1,
    BACK     = 2'd2,
    STRAIGHT = 2'd3
  } decision_t;

  // A junction needs a decision when a side opens or the front is blocked.
  function automatic logic decision_needed(input logic front, input logic left,
                                           input logic right);
    return !left || !right || front;
  endfunction

  // Left-hand rule: left, then straight, then right, otherwise turn back.
  function automatic decision_t choose_move(input logic front, input logic left,
                                            input logic right);
    if (!left) return LEFT;
    if (!front) return STRAIGHT;
    if (!right) return RIGHT;
    return BACK;
  endfunction

endpackage

// File: rtl/pattern_debounce.sv
// Holds the previous wall pattern and a saturating stable counter; 'stable'
// is high in the cycle where the pattern has held for DEBOUNCE consecutive cycles.
module pattern_debounce #(
  parameter int DEBOUNCE = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic run,
  input  logic front,
  input  logic left,
  input  logic right,
  output logic stable
);

  localparam logic [31:0] LIMIT = 32'(DEBOUNCE - 1);

  logic [2:0]  pattern;
  logic [2:0]  prev_reg;
  logic [31:0] count_reg;
  logic [31:0] count_next;

  assign pattern = {front, left, right};

  always_comb begin
    count_next = '0;
    if (pattern == prev_reg) begin
      count_next = (count_reg >= LIMIT) ? LIMIT : count_reg + 32'd1;
    end
  end

  // Uses the updated count so the decision lands in the last stable cycle.
  assign stable = run && (count_next == LIMIT);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      prev_reg  <= '0;
      count_reg <= '0;
    end else if (run) begin
      prev_reg  <= pattern;
      count_reg <= count_next;
    end
  end

endmodule

// File: rtl/auto_drive_ctrl.sv
// Auto-drive sequencer: debounces wall detectors, picks a move and hands turns
// to the turner. Define AUTO_DRIVE_STATS_EN to build the completed-turn counter.
module auto_drive_ctrl
  import car_pkg::*;
#(
  parameter int DEBOUNCE    = 4,
  parameter int SETTLE_TIME = 100,
  parameter int ACK_TIMEOUT = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       detect_front,
  input  logic       detect_left,
  input  logic       detect_right,
  input  logic       is_turning,
  output logic       trigger_turn_left,
  output logic       trigger_turn_right,
  output logic       trigger_turn_back,
  output logic       move_forward,
  output logic [2:0] state,
  output logic       fault,
  output logic [7:0] turn_count
);

  localparam logic [31:0] ACK_LAST    = 32'(ACK_TIMEOUT - 1);
  localparam logic [31:0] SETTLE_LAST = 32'(SETTLE_TIME - 1);

  state_t      state_reg, state_next;
  decision_t   decision_reg, decision_next;
  decision_t   move;
  logic [31:0] timer_reg, timer_next;
  logic        settle_exit;
  logic        stable;
  logic        need;

  logic move_forward_reg;
  logic trigger_left_reg, trigger_right_reg, trigger_back_reg;
  logic fault_reg;

  pattern_debounce #(
    .DEBOUNCE(DEBOUNCE)
  ) u_debounce (
    .clk   (clk),
    .rst   (rst),
    .clr   (!enable || settle_exit),
    .run   (state_reg == CRUISE),
    .front (detect_front),
    .left  (detect_left),
    .right (detect_right),
    .stable(stable)
  );

  assign need = decision_needed(detect_front, detect_left, detect_right);
  assign move = choose_move(detect_front, detect_left, detect_right);

  always_comb begin
    state_next    = state_reg;
    timer_next    = timer_reg;
    decision_next = decision_reg;
    settle_exit   = 1'b0;
    case (state_reg)
      IDLE: if (enable) state_next = CRUISE;
      CRUISE: begin
        if (stable && need) begin
          if (move == STRAIGHT) begin
            state_next = SETTLE;
            timer_next = '0;
          end else begin
            decision_next = move;
            state_next    = TRIGGER;
          end
        end
      end
      TRIGGER: begin
        state_next = WAIT_ACK;
        timer_next = '0;
      end
      WAIT_ACK: begin
        if (is_turning) begin
          state_next = WAIT_DONE;
        end else if (timer_reg >= ACK_LAST) begin
          state_next = FAULT;
        end else begin
          timer_next = timer_reg + 32'd1;
        end
      end
      WAIT_DONE: begin
        if (!is_turning) begin
          state_next = SETTLE;
          timer_next = '0;
        end
      end
      SETTLE: begin
        if (timer_reg >= SETTLE_LAST) begin
          state_next  = CRUISE;
          timer_next  = '0;
          settle_exit = 1'b1;
        end else begin
          timer_next = timer_reg + 32'd1;
        end
      end
      FAULT:   state_next = FAULT;
      default: state_next = IDLE;
    endcase
    // Dropping out of auto mode aborts everything except a latched fault.
    if (!enable && state_reg != FAULT) begin
      state_next  = IDLE;
      timer_next  = '0;
      settle_exit = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg         <= IDLE;
      timer_reg         <= '0;
      decision_reg      <= LEFT;
      move_forward_reg  <= 1'b0;
      trigger_left_reg  <= 1'b0;
      trigger_right_reg <= 1'b0;
      trigger_back_reg  <= 1'b0;
      fault_reg         <= 1'b0;
    end else begin
      state_reg         <= state_next;
      timer_reg         <= timer_next;
      decision_reg      <= decision_next;
      move_forward_reg  <= (state_next == CRUISE) || (state_next == SETTLE);
      trigger_left_reg  <= (state_next == TRIGGER) && (decision_next == LEFT);
      trigger_right_reg <= (state_next == TRIGGER) && (decision_next == RIGHT);
      trigger_back_reg  <= (state_next == TRIGGER) && (decision_next == BACK);
      fault_reg         <= (state_next == FAULT);
    end
  end

`ifdef AUTO_DRIVE_STATS_EN
  logic [7:0] turn_count_reg;
  logic       turn_done;

  assign turn_done = (state_reg == WAIT_DONE) && (state_next == SETTLE);

  // Survives enable drops; only reset clears the tally.
  always_ff @(posedge clk) begin
    if (rst) begin
      turn_count_reg <= '0;
    end else if (turn_done) begin
      turn_count_reg <= turn_count_reg + 8'd1;
    end
  end

  assign turn_count = turn_count_reg;
`else
  assign turn_count = 8'd0;
`endif

  assign state              = state_reg;
  assign move_forward       = move_forward_reg;
  assign trigger_turn_left  = trigger_left_reg;
  assign trigger_turn_right = trigger_right_reg;
  assign trigger_turn_back  = trigger_back_reg;
  assign fault              = fault_reg;

endmodule

// File: tb/tb_auto_drive_ctrl.sv
// Closed-loop bench for auto_drive_ctrl with a turner model and a cycle-level
// reference model; honours AUTO_DRIVE_STATS_EN for the turn counter.
module tb_auto_drive_ctrl;

  localparam int DEB = 4;
  localparam int SET = 10;
  localparam int ACK = 8;
  localparam int TURN_HOLD = 450;

  localparam int M_IDLE = 0, M_CRUISE = 1, M_TRIG = 2, M_ACK = 3;
  localparam int M_DONE = 4, M_SETTLE = 5, M_FAULT = 6;

  logic clk = 1'b0;
  logic rst, enable, detect_front, detect_left, detect_right, is_turning;
  logic trig_l, trig_r, trig_b, move_forward, fault;
  logic [2:0] state;
  logic [7:0] turn_count;

  always #5 clk = ~clk;

  auto_drive_ctrl #(
    .DEBOUNCE(DEB), .SETTLE_TIME(SET), .ACK_TIMEOUT(ACK)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .detect_front(detect_front), .detect_left(detect_left), .detect_right(detect_right),
    .is_turning(is_turning),
    .trigger_turn_left(trig_l), .trigger_turn_right(trig_r), .trigger_turn_back(trig_b),
    .move_forward(move_forward), .state(state), .fault(fault), .turn_count(turn_count)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: state, cycles spent in it, chosen turn (0 L, 1 R, 2 B)
  int m_state = M_IDLE;
  int m_age = 0;
  int m_dec = 0;
  int m_turns = 0;
  logic [2:0] hist[$];

  int turner_rem = 0;
  bit silent = 1'b0;
  logic [2:0] rnd_pat;
  bit rnd_en;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %0d expected %0d", tag, $time, got, exp);
    end
  endtask

  function automatic void model_step(input bit r, input bit en, input logic [2:0] pat,
                                     input bit busy);
    int nxt = m_state;
    bit f = pat[2], l = pat[1], rt = pat[0];
    bit all_same;
    if (r) begin
      nxt = M_IDLE;
      m_turns = 0;
    end else if (!en && m_state != M_FAULT) begin
      nxt = M_IDLE;
    end else begin
      case (m_state)
        M_IDLE: nxt = M_CRUISE;
        M_CRUISE: begin
          hist.push_back(pat);
          while (hist.size() > DEB) void'(hist.pop_front());
          all_same = (hist.size() == DEB);
          foreach (hist[i]) if (hist[i] != pat) all_same = 1'b0;
          if (all_same && (!l || !rt || f)) begin
            if (!l) begin m_dec = 0; nxt = M_TRIG; end
            else if (!f) nxt = M_SETTLE;
            else if (!rt) begin m_dec = 1; nxt = M_TRIG; end
            else begin m_dec = 2; nxt = M_TRIG; end
          end
        end
        M_TRIG: nxt = M_ACK;
        M_ACK: begin
          if (busy) nxt = M_DONE;
          else if (m_age == ACK - 1) nxt = M_FAULT;
        end
        M_DONE: if (!busy) begin nxt = M_SETTLE; m_turns++; end
        M_SETTLE: if (m_age == SET - 1) nxt = M_CRUISE;
        default: nxt = m_state;
      endcase
    end
    // Every CRUISE stint starts against an all-clear previous pattern.
    if (nxt == M_CRUISE && m_state != M_CRUISE) begin
      hist.delete();
      hist.push_back(3'b000);
    end
    m_age = (nxt == m_state) ? m_age + 1 : 0;
    m_state = nxt;
  endfunction

  task automatic tick(input bit r, input bit en, input logic [2:0] pat);
    int exp_tc;
    check("state", 32'(state), 32'(m_state));
    check("move_forward", 32'(move_forward), 32'(m_state == M_CRUISE || m_state == M_SETTLE));
    check("trig_left", 32'(trig_l), 32'(m_state == M_TRIG && m_dec == 0));
    check("trig_right", 32'(trig_r), 32'(m_state == M_TRIG && m_dec == 1));
    check("trig_back", 32'(trig_b), 32'(m_state == M_TRIG && m_dec == 2));
    check("fault", 32'(fault), 32'(m_state == M_FAULT));
`ifdef AUTO_DRIVE_STATS_EN
    exp_tc = m_turns % 256;
`else
    exp_tc = 0;
`endif
    check("turn_count", 32'(turn_count), 32'(exp_tc));
    is_turning = (turner_rem > 0);
    if (turner_rem > 0) turner_rem--;
    if (!silent && (trig_l || trig_r || trig_b)) turner_rem = TURN_HOLD;
    rst = r;
    enable = en;
    {detect_front, detect_left, detect_right} = pat;
    model_step(r, en, pat, is_turning);
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n, input bit r, input bit en, input logic [2:0] pat);
    for (int i = 0; i < n; i++) tick(r, en, pat);
  endtask

  initial begin
    rst = 1'b1;
    enable = 1'b0;
    is_turning = 1'b0;
    {detect_front, detect_left, detect_right} = 3'b011;
    @(posedge clk);
    #1;
    run(2, 1'b1, 1'b1, 3'b011);        // reset beats enable
    run(50, 1'b0, 1'b1, 3'b011);       // corridor
    run(10, 1'b0, 1'b1, 3'b001);       // left opening
    run(480, 1'b0, 1'b1, 3'b011);
    run(10, 1'b0, 1'b1, 3'b111);       // dead end
    run(480, 1'b0, 1'b1, 3'b011);
    run(10, 1'b0, 1'b1, 3'b110);       // right-only opening
    run(480, 1'b0, 1'b1, 3'b011);
    run(3, 1'b0, 1'b1, 3'b001);        // glitch shorter than debounce
    run(30, 1'b0, 1'b1, 3'b011);
    run(5, 1'b0, 1'b1, 3'b010);        // straight pass
    run(30, 1'b0, 1'b1, 3'b011);
    run(10, 1'b0, 1'b1, 3'b001);       // enable drop mid WAIT_DONE
    run(100, 1'b0, 1'b1, 3'b011);
    run(1, 1'b0, 1'b0, 3'b011);
    run(600, 1'b0, 1'b1, 3'b011);
    for (int s = 0; s < 500; s++) begin
      rnd_pat = 3'($urandom_range(7, 0));
      rnd_en = ($urandom_range(49, 0) != 0);
      run($urandom_range(8, 1), 1'b0, rnd_en, rnd_pat);
    end
    run(2, 1'b0, 1'b0, 3'b011);        // silent turner -> handshake fault
    turner_rem = 0;
    silent = 1'b1;
    run(20, 1'b0, 1'b1, 3'b011);
    run(20, 1'b0, 1'b1, 3'b111);
    run(3, 1'b0, 1'b0, 3'b111);
    run(3, 1'b0, 1'b1, 3'b111);
    run(1, 1'b1, 1'b1, 3'b111);
    run(5, 1'b0, 1'b0, 3'b011);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
